// File: rtl/timer_pkg.sv
// Shared register map, field layout and state encoding for the timer.
package timer_pkg;

    localparam logic [11:0] OFF_ID    = 12'h000;
    localparam logic [11:0] OFF_VER   = 12'h004;
    localparam logic [11:0] OFF_CTRL  = 12'h008;
    localparam logic [11:0] OFF_STATE = 12'h00C;
    localparam logic [11:0] OFF_LOAD  = 12'h010;
    localparam logic [11:0] OFF_CUR   = 12'h014;
    localparam logic [11:0] OFF_END   = 12'h018;

    localparam int START_BIT = 0;
    localparam int STOP_BIT  = 1;
    localparam int STATE_BIT = 0;
    localparam int VMAJ_LSB  = 8;
    localparam int VMIN_LSB  = 0;
    localparam int VFLD_W    = 8;

    localparam logic [31:0] ID_RST   = 32'h54494D52;
    localparam logic [7:0]  VMAJ_RST = 8'd1;
    localparam logic [7:0]  VMIN_RST = 8'd0;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/timer_if.sv
// APB configuration port bundle for the timer.
interface timer_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/timer_regs.sv
// APB decode for the timer: read mux, error flag and write strobes.
module timer_regs
    import timer_pkg::*;
#(
    parameter logic [31:0] ID_VALUE  = ID_RST,
    parameter logic [7:0]  VER_MAJOR = VMAJ_RST,
    parameter logic [7:0]  VER_MINOR = VMIN_RST
) (
    timer_if.slave      bus,
    input  state_e      state,
    input  logic [31:0] current,
    output logic        load_we,
    output logic [3:0]  load_strb,
    output logic [31:0] load_data,
    output logic        start,
    output logic        stop
);

    logic [9:0]  idx;
    logic        mapped;
    logic        wr;
    logic [31:0] rd;
    logic        sel_id, sel_ver, sel_ctrl;
    logic        sel_state, sel_load, sel_cur;
    logic        unused_addr;

    assign idx       = bus.paddr[11:2];
    assign mapped    = idx < OFF_END[11:2];
    assign sel_id    = idx == OFF_ID[11:2];
    assign sel_ver   = idx == OFF_VER[11:2];
    assign sel_ctrl  = idx == OFF_CTRL[11:2];
    assign sel_state = idx == OFF_STATE[11:2];
    assign sel_load  = idx == OFF_LOAD[11:2];
    assign sel_cur   = idx == OFF_CUR[11:2];

    assign unused_addr = ^{bus.paddr[31:12], bus.paddr[1:0]};

    // write-only registers fall through to the zero default
    always_comb begin
        rd = '0;
        unique case (1'b1)
            sel_id:    rd = ID_VALUE;
            sel_ver: begin
                rd[VMAJ_LSB +: VFLD_W] = VER_MAJOR;
                rd[VMIN_LSB +: VFLD_W] = VER_MINOR;
            end
            sel_state: rd[STATE_BIT] = (state == ST_RUNNING);
            sel_cur:   rd = current;
            default:   rd = '0;
        endcase
    end

    assign bus.pready  = 1'b1;
    assign bus.prdata  = (bus.psel && !bus.pwrite) ? rd : '0;
    assign bus.pslverr = bus.psel && !mapped;

    assign wr = bus.psel && bus.penable && bus.pwrite && mapped;

    assign load_we   = wr && sel_load;
    assign load_strb = bus.pstrb;
    assign load_data = bus.pwdata;

    assign start = wr && sel_ctrl && bus.pstrb[0]
                   && bus.pwdata[START_BIT];
    assign stop  = wr && sel_ctrl && bus.pstrb[0]
                   && bus.pwdata[STOP_BIT];

endmodule

// File: rtl/timer.sv
// Free-running 32-bit up-counter with start/stop control over APB.
module timer
    import timer_pkg::*;
#(
    parameter logic [31:0] ID_VALUE  = ID_RST,
    parameter logic [7:0]  VER_MAJOR = VMAJ_RST,
    parameter logic [7:0]  VER_MINOR = VMIN_RST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_cfg_in_m_paddr_0,
    input  logic        m_cfg_in_m_psel_0,
    input  logic        m_cfg_in_m_penable_0,
    input  logic        m_cfg_in_m_pwrite_0,
    input  logic [31:0] m_cfg_in_m_pwdata_0,
    input  logic [3:0]  m_cfg_in_m_pstrb_0,
    output logic        m_cfg_out_m_pready_0,
    output logic [31:0] m_cfg_out_m_prdata_0,
    output logic        m_cfg_out_m_pslverr_0
);

    timer_if cfg ();

    assign cfg.paddr   = m_cfg_in_m_paddr_0;
    assign cfg.psel    = m_cfg_in_m_psel_0;
    assign cfg.penable = m_cfg_in_m_penable_0;
    assign cfg.pwrite  = m_cfg_in_m_pwrite_0;
    assign cfg.pwdata  = m_cfg_in_m_pwdata_0;
    assign cfg.pstrb   = m_cfg_in_m_pstrb_0;

    assign m_cfg_out_m_pready_0  = cfg.pready;
    assign m_cfg_out_m_prdata_0  = cfg.prdata;
    assign m_cfg_out_m_pslverr_0 = cfg.pslverr;

    state_e      state_q, state_d;
    logic [31:0] cnt_q;
    logic        load_we, start, stop;
    logic [3:0]  load_strb;
    logic [31:0] load_data;

    timer_regs #(
        .ID_VALUE  (ID_VALUE),
        .VER_MAJOR (VER_MAJOR),
        .VER_MINOR (VER_MINOR)
    ) u_regs (
        .bus       (cfg.slave),
        .state     (state_q),
        .current   (cnt_q),
        .load_we   (load_we),
        .load_strb (load_strb),
        .load_data (load_data),
        .start     (start),
        .stop      (stop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_STOPPED;
        else      state_q <= state_d;
    end

    // STOP dominates when both control bits are written together
    always_comb begin
        state_d = state_q;
        if (stop)       state_d = ST_STOPPED;
        else if (start) state_d = ST_RUNNING;
    end

    // uses the registered state, so START counts from the next edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (load_we)
            cnt_q <= strb_merge(cnt_q, load_data, load_strb);
        else if (state_q == ST_RUNNING)
            cnt_q <= cnt_q + 32'd1;
    end

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for the APB timer.
module tb_timer;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    timer_if bus ();

    timer dut (
        .clk                   (clk),
        .rst                   (rst),
        .m_cfg_in_m_paddr_0    (bus.paddr),
        .m_cfg_in_m_psel_0     (bus.psel),
        .m_cfg_in_m_penable_0  (bus.penable),
        .m_cfg_in_m_pwrite_0   (bus.pwrite),
        .m_cfg_in_m_pwdata_0   (bus.pwdata),
        .m_cfg_in_m_pstrb_0    (bus.pstrb),
        .m_cfg_out_m_pready_0  (bus.pready),
        .m_cfg_out_m_prdata_0  (bus.prdata),
        .m_cfg_out_m_pslverr_0 (bus.pslverr)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input  logic [31:0] a,
                          input  logic [31:0] d,
                          input  logic [3:0]  s,
                          output logic        err);
        @(negedge clk);
        bus.paddr   = a;
        bus.pwdata  = d;
        bus.pstrb   = s;
        bus.pwrite  = 1'b1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        #1 err = bus.pslverr;
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input  logic [31:0] a,
                          output logic [31:0] d,
                          output logic        err);
        @(negedge clk);
        bus.paddr   = a;
        bus.pwrite  = 1'b0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        #1;
        d   = bus.prdata;
        err = bus.pslverr;
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;

        bus.paddr   = '0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.pwdata  = '0;
        bus.pstrb   = '0;

        repeat (3) @(negedge clk);
        chk("pready_rst", {31'h0, bus.pready}, 32'h1);
        rst = 1'b1;

        apb_rd(32'h00, d, e);
        chk("id", d, 32'h54494D52);
        chk("id_err", {31'h0, e}, 32'h0);
        apb_rd(32'h04, d, e);
        chk("ver", d, 32'h00000100);
        chk("ver_err", {31'h0, e}, 32'h0);
        apb_rd(32'h0C, d, e);
        chk("state_rst", d, 32'h0);
        apb_rd(32'h14, d, e);
        chk("cur_rst", d, 32'h0);

        apb_wr(32'h10, 32'h12345678, 4'hF, e);
        apb_rd(32'h14, d, e);
        chk("load_full", d, 32'h12345678);
        apb_wr(32'h10, 32'h000000AA, 4'h1, e);
        apb_rd(32'h14, d, e);
        chk("load_b0", d, 32'h123456AA);
        apb_rd(32'h10, d, e);
        chk("load_rd0", d, 32'h0);

        apb_wr(32'h08, 32'h1, 4'h2, e);
        apb_rd(32'h0C, d, e);
        chk("ctrl_nostrb", d, 32'h0);

        // start commits, 3 clocks of read, stop commits 6 edges later
        apb_wr(32'h08, 32'h1, 4'hF, e);
        apb_rd(32'h0C, d, e);
        chk("state_run", d, 32'h1);
        apb_wr(32'h08, 32'h2, 4'hF, e);
        apb_rd(32'h0C, d, e);
        chk("state_stop", d, 32'h0);
        apb_rd(32'h14, d, e);
        chk("cur_frozen", d, 32'h123456B0);
        chk("cur_range", {31'h0, (d >= 32'h12345678 && d <= 32'h12346000)}, 32'h1);
        apb_rd(32'h14, d, e);
        chk("cur_frozen2", d, 32'h123456B0);
        apb_rd(32'hFFF01016, d, e);
        chk("cur_alias", d, 32'h123456B0);
        apb_rd(32'h08, d, e);
        chk("ctrl_rd0", d, 32'h0);

        apb_wr(32'h10, 32'hFFFFFFFE, 4'hF, e);
        apb_wr(32'h08, 32'h1, 4'h1, e);
        apb_wr(32'h08, 32'h2, 4'h1, e);
        apb_rd(32'h14, d, e);
        chk("wrap", d, 32'h00000001);
        chk("wrap_range", {31'h0, (d <= 32'h4)}, 32'h1);

        apb_wr(32'h08, 32'h1, 4'h1, e);
        apb_rd(32'h0C, d, e);
        chk("run_again", d, 32'h1);
        apb_wr(32'h08, 32'h3, 4'h1, e);
        apb_rd(32'h0C, d, e);
        chk("ctrl_both", d, 32'h0);

        apb_wr(32'h10, 32'h0000BEEF, 4'hF, e);
        apb_rd(32'h20, d, e);
        chk("bad_rd_data", d, 32'h0);
        chk("bad_rd_err", {31'h0, e}, 32'h1);
        apb_wr(32'h20, 32'h1, 4'hF, e);
        chk("bad_wr_err", {31'h0, e}, 32'h1);
        apb_wr(32'h408, 32'h1, 4'hF, e);
        chk("hi_idx_err", {31'h0, e}, 32'h1);
        apb_wr(32'h18, 32'h1, 4'hF, e);
        chk("edge18_err", {31'h0, e}, 32'h1);
        apb_rd(32'h0C, d, e);
        chk("bad_no_state", d, 32'h0);
        apb_rd(32'h14, d, e);
        chk("bad_no_cur", d, 32'h0000BEEF);

        apb_wr(32'h00, 32'h0, 4'hF, e);
        chk("ro_wr_err", {31'h0, e}, 32'h0);
        apb_rd(32'h00, d, e);
        chk("ro_id", d, 32'h54494D52);

        // reset lands mid-transfer, before the LOAD can commit
        apb_wr(32'h08, 32'h1, 4'h1, e);
        repeat (5) @(negedge clk);
        bus.paddr   = 32'h10;
        bus.pwdata  = 32'h55;
        bus.pstrb   = 4'hF;
        bus.pwrite  = 1'b1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_pready", {31'h0, bus.pready}, 32'h1);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        apb_rd(32'h0C, d, e);
        chk("rst_state", d, 32'h0);
        apb_rd(32'h14, d, e);
        chk("rst_cur", d, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        apb_rd(32'h14, d, e);
        chk("post_rst_cur", d, 32'h0);
        apb_wr(32'h10, 32'h00000042, 4'hF, e);
        apb_rd(32'h14, d, e);
        chk("post_rst_load", d, 32'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have ports: clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have ports: m_cfg_in_m_paddr_0, input, 32, APB address.
REQ-004 SHALL have ports: m_cfg_in_m_psel_0, input, 1, APB select.
REQ-005 SHALL have ports: m_cfg_in_m_penable_0, input, 1, APB enable, marking the access phase.
REQ-006 SHALL have ports: m_cfg_in_m_pwrite_0, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have ports: m_cfg_in_m_pwdata_0, input, 32, write data.
REQ-008 SHALL have ports: m_cfg_in_m_pstrb_0, input, 4, write byte strobes.
REQ-009 SHALL have ports: m_cfg_out_m_pready_0, output, 1, transfer ready.
REQ-010 SHALL have ports: m_cfg_out_m_prdata_0, output, 32, read data.
REQ-011 SHALL have ports: m_cfg_out_m_pslverr_0, output, 1, transfer error.
REQ-012 SHALL have parameters: ID_VALUE, default 32'h54494D52, ID register content; VER_MAJOR, default 8'd1; VER_MINOR, default 8'd0.

Function
REQ-013 SHALL decode registers on paddr[11:2]; paddr[1:0] and paddr[31:12] are ignored.
REQ-014 SHALL map registers as follows: 0x00 ID (RO); 0x04 VERSION (RO, MAJOR [15:8], MINOR [7:0], other bits 0); 0x08 CONTROL (WO, START bit0, STOP bit1, reads 0); 0x0C STATE (RO, bit0: 0 = STOPPED, 1 = RUNNING, other bits 0); 0x10 LOAD (WO, reads 0); 0x14 CURRENT (RO, 32-bit counter).
REQ-015 SHALL tie pready to 1, so every transfer completes in its first access-phase cycle with zero wait states.
REQ-016 SHALL drive prdata combinationally from the decoded register when psel=1 and pwrite=0, and drive 0 otherwise.
REQ-017 SHALL drive pslverr=1 combinationally when psel=1 and the address is unmapped (0x18 and above), for both reads and writes; pslverr SHALL be 0 otherwise.
REQ-018 SHALL commit a write at the rising edge where psel=1, penable=1 and pwrite=1; writes with pslverr=1 or to RO registers are ignored without error.
REQ-019 SHALL apply a LOAD write per byte lane under pstrb to the CURRENT counter at that edge; CURRENT is visible on the following cycle.
REQ-020 SHALL act on CONTROL only if pstrb[0]=1: START sets state to RUNNING, STOP sets it to STOPPED; START and STOP together give STOPPED; START while running and STOP while stopped have no effect.
REQ-021 SHALL increment CURRENT by 1 on every clock edge while RUNNING, wrapping 0xFFFFFFFF to 0x00000000 and remaining RUNNING.
REQ-022 SHALL let a LOAD write in the same cycle as an increment win, and counting then continues from the loaded value.
REQ-023 SHALL hold CURRENT while STOPPED.
REQ-024 SHALL increment for the first time on the edge after the one that committed START, and SHALL make STOP freeze CURRENT at the value present after the committing edge.

Reset
REQ-025 SHALL set state to STOPPED and CURRENT to 0 immediately on rst=0, independent of clk.
REQ-026 SHALL hold pready=1, with prdata and pslverr following the combinational rules above, during reset.
REQ-027 SHALL discard any transfer in progress when reset asserts mid-transfer; the first access after reset release SHALL behave normally.

Structure
REQ-028 SHALL place register offsets, field LSBs and widths, reset values (ID, VERSION fields) and the state enum (STOPPED=0, RUNNING=1) in shared package timer_pkg.
REQ-029 SHALL split out one sub-module, timer_regs (APB decode, prdata/pslverr, write strobes), with the counter and state in the top level.

Verification
REQ-030 SHALL cover: after reset, read ID -> 0x54494D52; read VERSION -> 0x00000100; pslverr=0.
REQ-031 SHALL cover: after reset, read STATE -> 0 and CURRENT -> 0.
REQ-032 SHALL cover: write LOAD=0x12345678 with pstrb=0xF -> CURRENT reads 0x12345678; write with pstrb=0x1 and data 0xAA -> 0x123456AA.
REQ-033 SHALL cover: write CONTROL=0x1 -> STATE=1; then CONTROL=0x2 -> STATE=0, and CURRENT reads between 0x12345678 and 0x12346000 and is unchanged on a second read.
REQ-034 SHALL cover: LOAD 0xFFFFFFFE, start, stop after 4 cycles -> CURRENT wrapped to a small value (0x00000000 to 0x00000004); write CONTROL=0x3 while running -> STOPPED.
REQ-035 SHALL cover: read or write 0x20 -> pslverr=1, prdata=0, no state change; assert rst mid-run -> STATE=0, CURRENT=0.
